bomb_fuse_timer: RTL and testbench
==================================

Name: bomb_fuse_timer

Overview:
- Per-bomb fuse/explosion sequencer; generates the 4-bit bomb_state consumed by the bomb placement/explosion block.
- Watches that block's bomb_check flag, counts down the fuse in frames, then drives explosion and clear phases.
- Also provides warning-blink and explosion-animation outputs for the sprite renderer, and a one-frame explode pulse for sound/score logic.
- One instance per bomb slot.

Parameters:
- FUSE_FRAMES, 180, total fuse length in frames (3 s at 60 Hz); legal range 2..255.
- WARN_FRAMES, 60, final fuse frames during which blink is active; must be < FUSE_FRAMES.
- EXPLODE_FRAMES, 32, frames spent in the explosion phase; legal range 1..255.
- ANIM_DIV, 8, explosion frames per animation stage.
- BLINK_DIV, 4, frames per blink half-period.

Ports:
- frame_clk  in  1  frame clock (one rising edge per video frame); the only clock.
- Reset  in  1  synchronous, active-high reset.
- bomb_check  in  1  high while a bomb is placed in this slot.
- chain_hit  in  1  level; another explosion covers this bomb's tile.
- bomb_state  out  4  phase code to the bomb block (see Behaviour).
- fuse_left  out  8  remaining fuse frames; 0 outside ARMED.
- blink  out  1  sprite hide/show toggle during warning window.
- explode_stage  out  2  explosion animation frame index.
- explode_pulse  out  1  high for exactly one frame on entry to EXPLODE.

Behaviour:
- All state changes occur on posedge frame_clk.
- Reset is sampled synchronously and overrides all other inputs. It forces state IDLE, bomb_state=4'b0000, fuse_left=0, blink=0, explode_stage=0, explode_pulse=0, and clears all internal counters. Reset mid-fuse or mid-explosion aborts immediately.
- State encodings (also the bomb_state value):
  - IDLE=4'b0000
  - ARMED=4'b0010
  - EXPLODE=4'b0001
  - CLEAR=4'b1111
- bomb_state is registered and equals the current state.
- IDLE:
  - bomb_check=1 -> ARMED next edge; load fuse_left=FUSE_FRAMES-1.
  - Otherwise stay in IDLE.
- ARMED, evaluated in priority order:
  - (a) bomb_check=0 -> IDLE; bomb removed, no explosion, no pulse.
  - (b) chain_hit=1 -> EXPLODE next edge, regardless of fuse_left.
  - (c) fuse_left==0 -> EXPLODE.
  - (d) otherwise fuse_left decrements by 1.
- Fuse length: with no chain_hit, ARMED lasts exactly FUSE_FRAMES frames.
- Entering EXPLODE:
  - Load the explosion counter with 0.
  - explode_pulse=1 for that single frame.
  - fuse_left forced to 0.
- blink:
  - In ARMED with fuse_left < WARN_FRAMES, blink = bit of a free-running warn counter that toggles every BLINK_DIV frames, starting at 1 on the first warning frame.
  - blink=0 in every other state.
- EXPLODE:
  - The explosion counter increments each frame.
  - explode_stage = count/ANIM_DIV, saturating at 3.
  - When count==EXPLODE_FRAMES-1 -> CLEAR, so EXPLODE lasts exactly EXPLODE_FRAMES frames.
  - bomb_check and chain_hit are ignored during EXPLODE.
- CLEAR:
  - bomb_state=4'b1111.
  - Stay until bomb_check=0, then IDLE; the downstream block drops bomb_check one frame after seeing 1111.
  - bomb_check=1 in the same frame as the return to IDLE does not re-arm; re-arm needs bomb_check sampled high while in IDLE.
  - explode_stage resets to 0 on entry to CLEAR.
- Simultaneous chain_hit and fuse_left==0: single EXPLODE entry, one pulse.
- chain_hit in IDLE or CLEAR: no effect.
- Width rules: 8-bit unsigned counters with no wrap. Decrement never occurs below 0, and increment stops at EXPLODE_FRAMES-1.

Decomposition:
- Package bomb_pkg:
  - bomb_state_t enum (IDLE/ARMED/EXPLODE/CLEAR with the codes above), shared with the bomb block so that its 4'b0000/4'b0001/4'b1111 compares use named constants.
  - Default frame-count constants.
- One sub-module, frame_counter: loadable 8-bit up/down counter with enable and terminal flag.
  - Instantiated twice: fuse (down) and explosion (up).
- The FSM stays in bomb_fuse_timer.

Test Plan:
- Reset asserted mid-ARMED (fuse_left=100) -> next edge: bomb_state=0000, fuse_left=0, blink=0; stays IDLE while bomb_check=0.
- Normal fuse, defaults: bomb_check rises at frame 0 -> bomb_state=0010 at frame 1, fuse_left=179, then 0 at frame 180. bomb_state=0001 with explode_pulse=1 at frame 181 only. blink first high at frame 121 (fuse_left=59), toggling every 4 frames.
- Explosion animation -> explode_stage goes 0,1,2,3 at explosion frames 0,8,16,24. bomb_state=1111 at 32 frames after EXPLODE entry. bomb_check drops 1 frame later -> IDLE the following edge.
- chain_hit pulsed at fuse_left=150 -> EXPLODE next edge, one explode_pulse, fuse_left=0.
- bomb_check dropped at fuse_left=40 -> IDLE next edge, no explode_pulse, blink=0.
- chain_hit during EXPLODE and CLEAR, and bomb_check held high through CLEAR -> state remains in CLEAR, no second pulse; release bomb_check -> IDLE, then re-raise -> ARMED with fuse_left=179.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb fuse/explosion sequencer and the bomb block.
package bomb_pkg;

    // Phase codes seen by the bomb placement/explosion block on bomb_state.
    typedef enum logic [3:0] {
        IDLE    = 4'b0000,
        ARMED   = 4'b0010,
        EXPLODE = 4'b0001,
        CLEAR   = 4'b1111
    } bomb_state_t;

    // Default frame counts (60 Hz frame clock).
    localparam int unsigned DEF_FUSE_FRAMES    = 180;
    localparam int unsigned DEF_WARN_FRAMES    = 60;
    localparam int unsigned DEF_EXPLODE_FRAMES = 32;
    localparam int unsigned DEF_ANIM_DIV       = 8;
    localparam int unsigned DEF_BLINK_DIV      = 4;

    // Explosion animation stage from an explosion frame count, saturating at 3.
    function automatic logic [1:0] anim_stage(input logic [7:0] count, input logic [7:0] div);
        logic [7:0] raw;
        raw = count / div;
        if (raw > 8'd3) begin
            anim_stage = 2'd3;
        end else begin
            anim_stage = raw[1:0];
        end
    endfunction

endpackage

// File: rtl/bomb_fuse_timer_frame_counter.sv
// Loadable 8-bit up/down frame counter with enable, synchronous clear and
// terminal flag. Counting stops at the terminal value (0 when counting down,
// term_val when counting up), so the counter never wraps.
module frame_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    input  logic       up,
    input  logic [7:0] term_val,
    output logic [7:0] count,
    output logic       at_term
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear beats load beats counting; hold at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (up) begin
                if (count_q != term_val) begin
                    count_d = count_q + 8'd1;
                end else begin
                    count_d = count_q;
                end
            end else begin
                if (count_q != 8'd0) begin
                    count_d = count_q - 8'd1;
                end else begin
                    count_d = count_q;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_term = up ? (count_q == term_val) : (count_q == 8'd0);

endmodule

// File: rtl/bomb_fuse_timer.sv
// Per-bomb fuse/explosion sequencer: arms on bomb_check, counts the fuse down,
// runs the explosion animation, then holds CLEAR until the bomb block lets go.
module bomb_fuse_timer
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_FRAMES    = DEF_FUSE_FRAMES,
    parameter int unsigned WARN_FRAMES    = DEF_WARN_FRAMES,
    parameter int unsigned EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
    parameter int unsigned ANIM_DIV       = DEF_ANIM_DIV,
    parameter int unsigned BLINK_DIV      = DEF_BLINK_DIV
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       bomb_check,
    input  logic       chain_hit,
    output logic [3:0] bomb_state,
    output logic [7:0] fuse_left,
    output logic       blink,
    output logic [1:0] explode_stage,
    output logic       explode_pulse
);

    localparam logic [7:0] FUSE_LOAD = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] WARN_LIM  = 8'(WARN_FRAMES);
    localparam logic [7:0] EXPL_LAST = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0] ANIM_D    = 8'(ANIM_DIV);
    localparam logic [7:0] BLINK_TOP = 8'(BLINK_DIV - 1);

    bomb_state_t state_q, state_d;
    logic        pulse_q, pulse_d;
    logic [1:0]  stage_q, stage_d;
    logic        blink_q, blink_d;
    logic        warn_q, warn_d;
    logic [7:0]  div_q, div_d;

    logic        fuse_clr, fuse_load, fuse_en, fuse_term;
    logic [7:0]  fuse_cnt;
    logic        expl_clr, expl_en, expl_term;
    logic [7:0]  expl_cnt;

    frame_counter u_fuse (
        .clk      (frame_clk),
        .rst      (Reset),
        .clr      (fuse_clr),
        .load     (fuse_load),
        .load_val (FUSE_LOAD),
        .en       (fuse_en),
        .up       (1'b0),
        .term_val (8'd0),
        .count    (fuse_cnt),
        .at_term  (fuse_term)
    );

    frame_counter u_expl (
        .clk      (frame_clk),
        .rst      (Reset),
        .clr      (expl_clr),
        .load     (1'b0),
        .load_val (8'd0),
        .en       (expl_en),
        .up       (1'b1),
        .term_val (EXPL_LAST),
        .count    (expl_cnt),
        .at_term  (expl_term)
    );

    // Next state, counter controls and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        pulse_d   = 1'b0;
        stage_d   = 2'd0;
        warn_d    = 1'b0;
        fuse_clr  = 1'b0;
        fuse_load = 1'b0;
        fuse_en   = 1'b0;
        expl_clr  = 1'b0;
        expl_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bomb_check) begin
                    state_d   = ARMED;
                    fuse_load = 1'b1;
                    warn_d    = (FUSE_LOAD < WARN_LIM);
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (!bomb_check) begin
                    // Bomb removed: quiet return, fuse_left reads 0 again.
                    state_d  = IDLE;
                    fuse_clr = 1'b1;
                end else if (chain_hit || fuse_term) begin
                    // Chain hit and fuse expiry together still give one entry.
                    state_d  = EXPLODE;
                    fuse_clr = 1'b1;
                    expl_clr = 1'b1;
                    pulse_d  = 1'b1;
                end else begin
                    state_d = ARMED;
                    fuse_en = 1'b1;
                    warn_d  = ((fuse_cnt - 8'd1) < WARN_LIM);
                end
            end
            EXPLODE: begin
                if (expl_term) begin
                    state_d  = CLEAR;
                    expl_clr = 1'b1;
                end else begin
                    state_d = EXPLODE;
                    expl_en = 1'b1;
                    stage_d = anim_stage(expl_cnt + 8'd1, ANIM_D);
                end
            end
            CLEAR: begin
                if (!bomb_check) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d  = IDLE;
                fuse_clr = 1'b1;
                expl_clr = 1'b1;
            end
        endcase

        // Warning blink: starts shown on the first warning frame, then flips
        // every BLINK_DIV frames for as long as the window lasts.
        if (warn_d) begin
            if (warn_q) begin
                if (div_q == BLINK_TOP) begin
                    div_d   = 8'd0;
                    blink_d = ~blink_q;
                end else begin
                    div_d   = div_q + 8'd1;
                    blink_d = blink_q;
                end
            end else begin
                div_d   = 8'd0;
                blink_d = 1'b1;
            end
        end else begin
            div_d   = 8'd0;
            blink_d = 1'b0;
        end
    end

    // State and registered outputs; reset aborts any fuse or explosion.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            stage_q <= 2'd0;
            blink_q <= 1'b0;
            warn_q  <= 1'b0;
            div_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            stage_q <= stage_d;
            blink_q <= blink_d;
            warn_q  <= warn_d;
            div_q   <= div_d;
        end
    end

    assign bomb_state    = state_q;
    assign fuse_left     = fuse_cnt;
    assign blink         = blink_q;
    assign explode_stage = stage_q;
    assign explode_pulse = pulse_q;

endmodule

// File: tb/tb_bomb_fuse_timer.sv
// Scoreboard bench for bomb_fuse_timer: the stimulus side pushes the expected
// outputs for each frame edge, a monitor pops and compares after that edge.
module tb_bomb_fuse_timer;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       bomb_check = 1'b0;
    logic       chain_hit = 1'b0;
    logic [3:0] bomb_state;
    logic [7:0] fuse_left;
    logic       blink;
    logic [1:0] explode_stage;
    logic       explode_pulse;

    typedef struct {
        string      nm;
        logic [3:0] st;
        logic [7:0] fl;
        logic       bl;
        logic [1:0] es;
        logic       ep;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_mis = 0;

    localparam logic [3:0] S_IDLE = 4'b0000;
    localparam logic [3:0] S_ARM  = 4'b0010;
    localparam logic [3:0] S_EXP  = 4'b0001;
    localparam logic [3:0] S_CLR  = 4'b1111;

    bomb_fuse_timer dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .bomb_check    (bomb_check),
        .chain_hit     (chain_hit),
        .bomb_state    (bomb_state),
        .fuse_left     (fuse_left),
        .blink         (blink),
        .explode_stage (explode_stage),
        .explode_pulse (explode_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: one expectation per frame edge, compared 1 ns after the edge.
    always @(posedge frame_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (bomb_state !== mon_e.st || fuse_left !== mon_e.fl || blink !== mon_e.bl ||
                explode_stage !== mon_e.es || explode_pulse !== mon_e.ep) begin
                n_mis++;
                $display("FAIL %s @%0t: got st=%b fl=%0d bl=%b es=%0d ep=%b, want st=%b fl=%0d bl=%b es=%0d ep=%b",
                         mon_e.nm, $time, bomb_state, fuse_left, blink, explode_stage, explode_pulse,
                         mon_e.st, mon_e.fl, mon_e.bl, mon_e.es, mon_e.ep);
            end
        end
    end

    // Drive inputs for the next edge and queue what that edge must produce.
    task automatic step(input logic r, input logic bc, input logic ch, input string nm,
                        input logic [3:0] st, input logic [7:0] fl, input logic bl,
                        input logic [1:0] es, input logic ep);
        exp_t e;
        @(negedge frame_clk);
        Reset      = r;
        bomb_check = bc;
        chain_hit  = ch;
        e.nm = nm; e.st = st; e.fl = fl; e.bl = bl; e.es = es; e.ep = ep;
        exp_q.push_back(e);
    endtask

    // Expected blink at ARMED frame k (frame 1 = first ARMED frame, fuse_left=180-k).
    function automatic logic blink_at(input int k);
        if (k >= 121) return (((k - 121) / 4) % 2 == 0);
        else return 1'b0;
    endfunction

    // Arm from IDLE, then run the fuse through frame last_k.
    task automatic arm_run(input int last_k);
        step(1'b0, 1'b1, 1'b0, "arm", S_ARM, 8'd179, 1'b0, 2'd0, 1'b0);
        for (int k = 2; k <= last_k; k++)
            step(1'b0, 1'b1, 1'b0, "fuse", S_ARM, 8'(180 - k), blink_at(k), 2'd0, 1'b0);
    endtask

    // Explosion frames 1..31 after the entry frame, then CLEAR entry.
    task automatic explode_run(input logic ch);
        int s;
        for (int e = 1; e <= 31; e++) begin
            s = (e / 8 > 3) ? 3 : e / 8;
            step(1'b0, 1'b1, ch, "expl", S_EXP, 8'd0, 1'b0, 2'(s), 1'b0);
        end
        step(1'b0, 1'b1, ch, "clear_entry", S_CLR, 8'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        // Reset state, then idle with nothing placed.
        step(1'b1, 1'b0, 1'b0, "reset", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, "reset_ovr", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, "idle_chain", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);

        // Normal fuse: explode at frame 181, then CLEAR with chain_hit and
        // bomb_check held, release, and re-arm.
        arm_run(180);
        step(1'b0, 1'b1, 1'b0, "expl_entry", S_EXP, 8'd0, 1'b0, 2'd0, 1'b1);
        explode_run(1'b1);
        step(1'b0, 1'b1, 1'b1, "clear_hold", S_CLR, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, "clear_hold", S_CLR, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "clear_rel", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "idle", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);

        // Chain hit at fuse_left=150 (frame 30).
        arm_run(30);
        step(1'b0, 1'b1, 1'b1, "chain_entry", S_EXP, 8'd0, 1'b0, 2'd0, 1'b1);
        explode_run(1'b0);
        step(1'b0, 1'b0, 1'b0, "clear_rel2", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);

        // bomb_check dropped at fuse_left=40 (frame 140), inside the warning window.
        arm_run(140);
        step(1'b0, 1'b0, 1'b0, "removed", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "removed_idle", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);

        // Reset at fuse_left=100 (frame 80).
        arm_run(80);
        step(1'b1, 1'b1, 1'b0, "reset_armed", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "post_reset", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "post_reset", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);

        // Reset mid-explosion, chain hit on the fuse's last frame gives one entry.
        arm_run(180);
        step(1'b0, 1'b1, 1'b1, "chain_at_zero", S_EXP, 8'd0, 1'b0, 2'd0, 1'b1);
        for (int e = 1; e <= 9; e++)
            step(1'b0, 1'b1, 1'b1, "expl_short", S_EXP, 8'd0, 1'b0, 2'(e / 8), 1'b0);
        step(1'b1, 1'b1, 1'b0, "reset_expl", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, "post_reset2", S_IDLE, 8'd0, 1'b0, 2'd0, 1'b0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge frame_clk);
        #2;
        if (exp_q.size() > 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
